// File: rtl/fracdiv_retune_seq.sv
// Retune sequencer for the fractional clock divider.
// Accepts an (m, n) target, applies it only on divider-output rising edges,
// slews n in bounded steps, then waits a settle window before reporting lock.
module fracdiv_retune_seq #(
   parameter int unsigned MLEN         = 16,
   parameter int unsigned NLEN         = 16,
   parameter int unsigned SETTLE_EDGES = 4,
   parameter int unsigned EDGE_TIMEOUT = 65535
) (
   input  logic            clk_fast,
   input  logic            rst_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [MLEN-1:0] cfg_m,
   input  logic [NLEN-1:0] cfg_n,
   input  logic [NLEN-1:0] cfg_nstep,
   input  logic            abort,
   input  logic            div_clk,
   output logic [MLEN-1:0] div_m,
   output logic [NLEN-1:0] div_n,
   output logic            busy,
   output logic            done,
   output logic            locked
);

   localparam int unsigned   TW          = $clog2(EDGE_TIMEOUT);
   localparam logic [TW-1:0] TimeoutLast = TW'(EDGE_TIMEOUT - 1);
   localparam logic [7:0]    SettleLast  = 8'(SETTLE_EDGES);

   typedef enum logic [1:0] {StIdle, StWaitEdge, StRamp, StSettle} state_e;

   state_e          state_q;
   logic            div_clk_q;
   logic [TW-1:0]   to_cnt_q;
   logic [MLEN-1:0] tgt_m_q;
   logic [NLEN-1:0] tgt_n_q;
   logic [NLEN-1:0] step_q;
   logic [7:0]      settle_cnt_q;

   logic            tick;
   logic            accept;
   logic            n_up;
   logic [NLEN-1:0] n_dist;
   logic [NLEN-1:0] n_next;

   assign accept = cfg_valid & cfg_ready;
   // A stalled divider (constant div_clk) still advances via the forced tick.
   assign tick   = (div_clk & ~div_clk_q) | (to_cnt_q == TimeoutLast);

   // Edge detector and divider-stall timeout counter.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         div_clk_q <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         div_clk_q <= div_clk;
         if (accept || tick) begin
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
      end
   end

   // Next n: one bounded step toward the target; distance is compared before
   // any subtraction so the unsigned value never wraps.
   always_comb begin
      n_up   = tgt_n_q > div_n;
      n_dist = n_up ? (tgt_n_q - div_n) : (div_n - tgt_n_q);
      if ((step_q == '0) || (n_dist <= step_q)) begin
         n_next = tgt_n_q;
      end else if (n_up) begin
         n_next = div_n + step_q;
      end else begin
         n_next = div_n - step_q;
      end
   end

   // Sequencer FSM with registered outputs; abort outranks a tick.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         tgt_m_q      <= '0;
         tgt_n_q      <= '0;
         step_q       <= '0;
         settle_cnt_q <= '0;
         div_m        <= '0;
         div_n        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         locked       <= 1'b0;
         cfg_ready    <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  tgt_m_q   <= cfg_m;
                  tgt_n_q   <= cfg_n;
                  step_q    <= cfg_nstep;
                  locked    <= 1'b0;
                  busy      <= 1'b1;
                  cfg_ready <= 1'b0;
                  state_q   <= StWaitEdge;
               end
            end
            StWaitEdge, StRamp: begin
               if (abort) begin
                  busy      <= 1'b0;
                  locked    <= 1'b0;
                  cfg_ready <= 1'b1;
                  state_q   <= StIdle;
               end else if (tick) begin
                  if (state_q == StWaitEdge) begin
                     div_m <= tgt_m_q;
                  end
                  div_n <= n_next;
                  if (n_next == tgt_n_q) begin
                     settle_cnt_q <= '0;
                     state_q      <= StSettle;
                  end else begin
                     state_q <= StRamp;
                  end
               end
            end
            StSettle: begin
               if (abort) begin
                  busy      <= 1'b0;
                  locked    <= 1'b0;
                  cfg_ready <= 1'b1;
                  state_q   <= StIdle;
               end else if (settle_cnt_q == SettleLast) begin
                  done      <= 1'b1;
                  locked    <= 1'b1;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
                  state_q   <= StIdle;
               end else if (tick) begin
                  settle_cnt_q <= settle_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fracdiv_retune_seq.sv
// Bench for fracdiv_retune_seq: a plan-based behavioural model checked every
// cycle, plus directed literal checks for the jump, ramps, stall, abort, reset.
module tb_fracdiv_retune_seq;

   localparam int unsigned SE = 4;
   localparam int unsigned ET = 40;

   typedef int q_t[$];

   logic        clk_fast  = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        abort     = 1'b0;
   logic        div_clk   = 1'b0;
   logic [15:0] cfg_m     = '0;
   logic [15:0] cfg_n     = '0;
   logic [15:0] cfg_nstep = '0;
   logic        cfg_ready;
   logic [15:0] div_m;
   logic [15:0] div_n;
   logic        busy;
   logic        done;
   logic        locked;

   int n_checks = 0;
   int n_pass   = 0;

   fracdiv_retune_seq #(
      .MLEN         (16),
      .NLEN         (16),
      .SETTLE_EDGES (SE),
      .EDGE_TIMEOUT (ET)
   ) dut (
      .clk_fast  (clk_fast),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_m     (cfg_m),
      .cfg_n     (cfg_n),
      .cfg_nstep (cfg_nstep),
      .abort     (abort),
      .div_clk   (div_clk),
      .div_m     (div_m),
      .div_n     (div_n),
      .busy      (busy),
      .done      (done),
      .locked    (locked)
   );

   always #5 clk_fast = ~clk_fast;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sequence of n values a retune visits, one per applied edge.
   function automatic q_t make_plan(input int cur, input int tgt, input int step);
      q_t p;
      int c;
      int d;
      c = cur;
      while (c != tgt) begin
         d = (tgt > c) ? tgt - c : c - tgt;
         if (step == 0 || d <= step) c = tgt;
         else if (tgt > c) c = c + step;
         else c = c - step;
         p.push_back(c);
      end
      return p;
   endfunction

   // Behavioural model: expected outputs after each clock edge.
   logic [15:0] exp_m      = '0;
   logic [15:0] exp_n      = '0;
   logic [15:0] tgt_m      = '0;
   logic        exp_busy   = 1'b0;
   logic        exp_done   = 1'b0;
   logic        exp_locked = 1'b0;
   logic        exp_ready  = 1'b1;
   bit          m_active   = 1'b0;
   bit          m_first    = 1'b0;
   bit          m_prev     = 1'b0;
   int          m_to       = 0;
   int          m_settle   = 0;
   q_t          m_plan;

   initial begin : model
      bit edge_now;
      forever begin
         @(posedge clk_fast or negedge rst_n);
         if (!rst_n) begin
            exp_m = '0; exp_n = '0; exp_busy = 1'b0; exp_done = 1'b0;
            exp_locked = 1'b0; exp_ready = 1'b1;
            m_active = 1'b0; m_first = 1'b0; m_prev = 1'b0; m_to = 0; m_settle = 0;
            m_plan.delete();
         end else begin
            edge_now = (div_clk && !m_prev) || (m_to == int'(ET) - 1);
            m_prev   = div_clk;
            exp_done = 1'b0;
            if (!m_active) begin
               if (cfg_valid) begin
                  tgt_m      = cfg_m;
                  m_plan     = make_plan(int'(exp_n), int'(cfg_n), int'(cfg_nstep));
                  m_first    = 1'b1;
                  m_settle   = SE;
                  m_active   = 1'b1;
                  exp_busy   = 1'b1;
                  exp_locked = 1'b0;
                  exp_ready  = 1'b0;
                  m_to       = 0;
               end else begin
                  m_to = edge_now ? 0 : m_to + 1;
               end
            end else begin
               m_to = edge_now ? 0 : m_to + 1;
               if (abort) begin
                  m_active   = 1'b0;
                  exp_busy   = 1'b0;
                  exp_locked = 1'b0;
                  exp_ready  = 1'b1;
                  m_plan.delete();
               end else if (m_first) begin
                  if (edge_now) begin
                     m_first = 1'b0;
                     exp_m   = tgt_m;
                     if (m_plan.size() > 0) exp_n = 16'(m_plan.pop_front());
                  end
               end else if (m_plan.size() > 0) begin
                  if (edge_now) exp_n = 16'(m_plan.pop_front());
               end else if (m_settle == 0) begin
                  m_active   = 1'b0;
                  exp_busy   = 1'b0;
                  exp_done   = 1'b1;
                  exp_locked = 1'b1;
                  exp_ready  = 1'b1;
               end else if (edge_now) begin
                  m_settle--;
               end
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin : compare
      forever begin
         @(negedge clk_fast);
         check("cycle", {div_m, div_n, busy, done, locked, cfg_ready},
               {exp_m, exp_n, exp_busy, exp_done, exp_locked, exp_ready});
      end
   end

   task automatic do_accept(input logic [15:0] m, input logic [15:0] n, input logic [15:0] s);
      @(negedge clk_fast);
      cfg_valid = 1'b1; cfg_m = m; cfg_n = n; cfg_nstep = s;
      @(negedge clk_fast);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse();
      @(negedge clk_fast);
      div_clk = 1'b1;
      @(negedge clk_fast);
      div_clk = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles, input bit pulses);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk_fast);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (pulses) div_clk = (i % 3 == 0);
      end
      div_clk = 1'b0;
      check(name, seen, 1'b1);
   endtask

   initial begin : stim
      q_t pin;
      pin = make_plan(32'h9000, 32'h2500, 32'h3000);
      check("plan_len", pin.size(), 3);
      check("plan_first", pin[0], 32'h6000);
      check("plan_last", pin[2], 32'h2500);

      repeat (3) @(negedge clk_fast);
      check("rst_vals", {div_m, div_n, busy, done, locked, cfg_ready}, {32'h0, 4'b0001});
      rst_n = 1'b1;

      // Jump
      do_accept(16'd3, 16'h8000, 16'h0);
      check("jump_busy", {busy, cfg_ready}, 2'b10);
      pulse();
      check("jump_mn", {div_m, div_n}, {16'd3, 16'h8000});
      repeat (4) pulse();
      check("jump_not_yet", done, 1'b0);
      @(negedge clk_fast);
      check("jump_done", {done, locked, busy, cfg_ready}, 4'b1101);

      // Up-ramp
      do_accept(16'd3, 16'h1000, 16'h0);
      wait_done("up_prep_done", 200, 1'b1);
      do_accept(16'd5, 16'h4000, 16'h1000);
      pulse(); check("up_1", {div_m, div_n}, {16'd5, 16'h2000});
      pulse(); check("up_2", div_n, 16'h3000);
      pulse(); check("up_3", div_n, 16'h4000);
      wait_done("up_done", 200, 1'b1);
      check("up_lock", {locked, div_n}, {1'b1, 16'h4000});

      // Down-ramp, non-multiple, with back-pressure
      do_accept(16'd3, 16'h9000, 16'h0);
      wait_done("down_prep_done", 200, 1'b1);
      do_accept(16'd7, 16'h2500, 16'h3000);
      pulse(); check("down_1", div_n, 16'h6000);
      @(negedge clk_fast);
      cfg_valid = 1'b1; cfg_m = 16'd9; cfg_n = 16'h1234; cfg_nstep = 16'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_fast);
         check("bp_ready", cfg_ready, 1'b0);
      end
      cfg_valid = 1'b0;
      pulse(); check("down_2", div_n, 16'h3000);
      pulse(); check("down_3", div_n, 16'h2500);
      wait_done("down_done", 200, 1'b1);
      check("down_final", {div_m, div_n}, {16'd7, 16'h2500});

      // Stalled divider: only forced steps
      do_accept(16'd2, 16'h2000, 16'h0100);
      repeat (30) @(negedge clk_fast);
      check("stall_hold", div_n, 16'h2500);
      wait_done("stall_done", 1000, 1'b0);
      check("stall_final", {div_m, div_n, locked}, {16'd2, 16'h2000, 1'b1});

      // Abort in IDLE is ignored
      @(negedge clk_fast); abort = 1'b1;
      @(negedge clk_fast); abort = 1'b0;
      check("idle_abort", {locked, cfg_ready, busy}, 3'b110);

      // Abort mid-ramp, coincident with a div_clk rise
      do_accept(16'd4, 16'h8000, 16'h1000);
      pulse(); check("abort_1", div_n, 16'h3000);
      pulse(); check("abort_2", div_n, 16'h4000);
      @(negedge clk_fast); abort = 1'b1; div_clk = 1'b1;
      @(negedge clk_fast); abort = 1'b0; div_clk = 1'b0;
      check("abort_state", {busy, cfg_ready, locked, done, div_n},
            {1'b0, 1'b1, 1'b0, 1'b0, 16'h4000});
      repeat (3) pulse();
      check("abort_frozen", {div_n, done}, {16'h4000, 1'b0});

      // Reset mid-ramp
      do_accept(16'd6, 16'hF000, 16'h1000);
      pulse(); check("rst_pre_1", div_n, 16'h5000);
      pulse(); check("rst_pre_2", div_n, 16'h6000);
      @(posedge clk_fast);
      #2 rst_n = 1'b0;
      #1 check("rst_mid", {div_m, div_n, busy, done, locked, cfg_ready}, {32'h0, 4'b0001});
      repeat (2) @(negedge clk_fast);
      rst_n = 1'b1;

      // Tick coincident with accept is ignored
      @(negedge clk_fast);
      cfg_valid = 1'b1; cfg_m = 16'd1; cfg_n = 16'h0010; cfg_nstep = 16'h0; div_clk = 1'b1;
      @(negedge clk_fast);
      cfg_valid = 1'b0; div_clk = 1'b0;
      check("acc_tick_ignored", {busy, div_m, div_n}, {1'b1, 16'd0, 16'h0});
      wait_done("final_done", 200, 1'b1);
      check("final", {div_m, div_n, locked}, {16'd1, 16'h0010, 1'b1});

      repeat (3) @(negedge clk_fast);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
